// File: rtl/if_byte_fetcher_if.sv
// ---------------------------------------------------------------------------
// if_byte_fetcher_if
//
// Bundles every non-clock/reset signal of the instruction byte fetcher:
//   request side  : req_valid_i, req_pc_i -> req_ready_o, plus flush_i
//   arbiter side  : pc_address_o, pc_valid_o -> stall_if_i, ram_byte_i
//   decode side   : inst_o, inst_pc_o, inst_valid_o <- stall_id_i
//
// Modports:
//   master : the fetcher itself (drives the *_o signals)
//   slave  : the surrounding system (drives the *_i signals)
// ---------------------------------------------------------------------------
interface if_byte_fetcher_if #(
  parameter int ADDR_W = 32,
  parameter int NBYTES = 4
);
  // request from pc_reg
  logic                  req_valid_i;
  logic [ADDR_W-1:0]     req_pc_i;
  logic                  req_ready_o;
  logic                  flush_i;
  // byte read channel towards the memory arbiter
  logic [ADDR_W-1:0]     pc_address_o;
  logic                  pc_valid_o;
  logic                  stall_if_i;
  logic [7:0]            ram_byte_i;
  // assembled instruction towards ID
  logic [8*NBYTES-1:0]   inst_o;
  logic [ADDR_W-1:0]     inst_pc_o;
  logic                  inst_valid_o;
  logic                  stall_id_i;

  modport master (
    input  req_valid_i, req_pc_i, flush_i, stall_if_i, ram_byte_i, stall_id_i,
    output req_ready_o, pc_address_o, pc_valid_o, inst_o, inst_pc_o, inst_valid_o
  );

  modport slave (
    output req_valid_i, req_pc_i, flush_i, stall_if_i, ram_byte_i, stall_id_i,
    input  req_ready_o, pc_address_o, pc_valid_o, inst_o, inst_pc_o, inst_valid_o
  );
endinterface

// File: rtl/if_byte_fetcher.sv
// ---------------------------------------------------------------------------
// if_byte_fetcher
//
// Instruction-fetch sequencer sitting in front of the memory arbiter. One
// accepted fetch request (a PC) becomes NBYTES serial byte reads; the returned
// bytes are assembled little-endian into one instruction word for ID.
//
// Ports:
//   clk  : system clock
//   rst  : synchronous reset, active low
//   bus  : if_byte_fetcher_if.master
//          req_valid_i/req_pc_i/req_ready_o : fetch request handshake
//          flush_i                          : abort current fetch (redirect)
//          pc_address_o/pc_valid_o          : byte read request to arbiter
//          stall_if_i                       : arbiter gave the bus to MEM
//          ram_byte_i                       : byte returned one cycle later
//          inst_o/inst_pc_o/inst_valid_o    : assembled instruction to ID
//          stall_id_i                       : ID back-pressure
//
// Timing with no stalls: accept at cycle 0, issues at 1..NBYTES, bytes back
// at 2..NBYTES+1, one DONE cycle, inst_valid_o high at cycle NBYTES+3.
// ---------------------------------------------------------------------------
module if_byte_fetcher #(
  parameter int ADDR_W = 32,
  parameter int NBYTES = 4
) (
  input  logic              clk,
  input  logic              rst,
  if_byte_fetcher_if.master bus
);

  localparam int               IDX_W    = $clog2(NBYTES + 1);
  localparam int               INST_W   = 8 * NBYTES;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);
  localparam logic [IDX_W-1:0] FULL_IDX = IDX_W'(NBYTES);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   base_pc_reg, base_pc_next;
  logic [IDX_W-1:0]    issue_idx_reg, issue_idx_next;
  logic [IDX_W-1:0]    recv_idx_reg, recv_idx_next;
  logic                inflight_reg, inflight_next;
  logic [INST_W-1:0]   inst_reg, inst_next;
  logic [ADDR_W-1:0]   inst_pc_reg, inst_pc_next;
  logic                inst_valid_reg, inst_valid_next;

  logic [INST_W-1:0]   assembled;
  logic [ADDR_W-1:0]   pc_address;
  logic                pc_valid;
  logic                granted;
  logic                rx_en;
  logic                out_free;
  logic                req_ready;
  logic                accept;

  // -------------------------------------------------------------------------
  // Next-state / output logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next      = state_reg;
    base_pc_next    = base_pc_reg;
    issue_idx_next  = issue_idx_reg;
    recv_idx_next   = recv_idx_reg;
    // inflight only describes the issue made in the current cycle
    inflight_next   = 1'b0;
    inst_next       = inst_reg;
    inst_pc_next    = inst_pc_reg;
    // a valid word drops once ID takes it
    inst_valid_next = inst_valid_reg & bus.stall_id_i;
    pc_valid        = 1'b0;
    pc_address      = '0;
    granted         = 1'b0;
    rx_en           = 1'b0;

    out_free  = ~inst_valid_reg | ~bus.stall_id_i;
    req_ready = rst & (state_reg == IDLE) & out_free;
    // a redirect may start a new fetch whatever the current state
    accept    = bus.req_valid_i & (req_ready | bus.flush_i);

    case (state_reg)
      FETCH: begin
        if (issue_idx_reg < FULL_IDX) begin
          pc_valid   = 1'b1;
          pc_address = base_pc_reg + ADDR_W'(issue_idx_reg);
        end
        // a stalled issue leaves issue_idx alone so the same address repeats
        granted = pc_valid & ~bus.stall_if_i;
        if (granted) begin
          issue_idx_next = issue_idx_reg + IDX_ONE;
          inflight_next  = 1'b1;
        end
        // the byte for last cycle's granted issue is on ram_byte_i now
        if (inflight_reg) begin
          rx_en         = 1'b1;
          recv_idx_next = recv_idx_reg + IDX_ONE;
          if (recv_idx_reg == LAST_IDX) begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        inst_next       = assembled;
        inst_pc_next    = base_pc_reg;
        inst_valid_next = 1'b1;
        state_next      = IDLE;
      end
      default: begin
      end
    endcase

    if (bus.flush_i) begin
      state_next      = IDLE;
      issue_idx_next  = '0;
      recv_idx_next   = '0;
      inflight_next   = 1'b0;
      rx_en           = 1'b0;
      inst_next       = inst_reg;
      inst_pc_next    = inst_pc_reg;
      inst_valid_next = 1'b0;
    end

    if (accept) begin
      state_next     = FETCH;
      base_pc_next   = bus.req_pc_i;
      issue_idx_next = '0;
      recv_idx_next  = '0;
      inflight_next  = 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg      <= IDLE;
      base_pc_reg    <= '0;
      issue_idx_reg  <= '0;
      recv_idx_reg   <= '0;
      inflight_reg   <= 1'b0;
      inst_reg       <= '0;
      inst_pc_reg    <= '0;
      inst_valid_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      base_pc_reg    <= base_pc_next;
      issue_idx_reg  <= issue_idx_next;
      recv_idx_reg   <= recv_idx_next;
      inflight_reg   <= inflight_next;
      inst_reg       <= inst_next;
      inst_pc_reg    <= inst_pc_next;
      inst_valid_reg <= inst_valid_next;
    end
  end

  // -------------------------------------------------------------------------
  // Byte lanes: lane gi captures the byte received while recv_idx == gi and
  // lands at bits [8*gi +: 8] of the word (byte 0 least significant).
  // -------------------------------------------------------------------------
  for (genvar gi = 0; gi < NBYTES; gi++) begin : g_lane
    logic [7:0] lane_reg;

    always_ff @(posedge clk) begin
      if (!rst) begin
        lane_reg <= '0;
      end else if (rx_en && (recv_idx_reg == IDX_W'(gi))) begin
        lane_reg <= bus.ram_byte_i;
      end
    end

    assign assembled[8*gi +: 8] = lane_reg;
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.req_ready_o  = req_ready;
  assign bus.pc_valid_o   = pc_valid;
  assign bus.pc_address_o = pc_address;
  assign bus.inst_o       = inst_reg;
  assign bus.inst_pc_o    = inst_pc_reg;
  assign bus.inst_valid_o = inst_valid_reg;

endmodule

// File: tb/tb_if_byte_fetcher.sv
// ---------------------------------------------------------------------------
// tb_if_byte_fetcher
//
// Directed scenarios with hand-computed expectations, followed by a random
// phase. A behavioural model (counters of bytes issued/received plus a
// memory function) is compared against the DUT on every cycle.
// ---------------------------------------------------------------------------
module tb_if_byte_fetcher;
  localparam int ADDR_W = 32;
  localparam int NBYTES = 4;

  logic clk = 1'b0;
  logic rst;
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_pass = 0;

  if_byte_fetcher_if #(.ADDR_W(ADDR_W), .NBYTES(NBYTES)) bus ();

  if_byte_fetcher #(.ADDR_W(ADDR_W), .NBYTES(NBYTES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory contents seen by the fetcher
  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    case (a)
      32'h1000: return 8'h13;
      32'h1001: return 8'h05;
      32'h1002: return 8'h10;
      32'h1003: return 8'h00;
      32'h2000: return 8'h93;
      32'h2001: return 8'h00;
      32'h2002: return 8'h50;
      32'h2003: return 8'h00;
      default:  return (a[7:0] * 8'd7) ^ a[15:8] ^ a[31:24] ^ 8'h5A;
    endcase
  endfunction

  // Little-endian word at base, addresses wrapping mod 2^32
  function automatic logic [31:0] ref_word(input logic [31:0] base);
    logic [31:0] w;
    w = '0;
    for (int k = 0; k < NBYTES; k++) begin
      w = w | (32'(mem_byte(base + 32'(k))) << (8 * k));
    end
    return w;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (act === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- RAM responder: one byte after each granted issue -------
  logic       ram_pend = 1'b0;
  logic [7:0] ram_val  = '0;

  always @(negedge clk) begin
    ram_pend = (bus.pc_valid_o === 1'b1) && (bus.stall_if_i === 1'b0);
    ram_val  = mem_byte(bus.pc_address_o);
  end

  always @(posedge clk) begin
    #1;
    bus.ram_byte_i = ram_pend ? ram_val : 8'($urandom);
  end

  // ---------------- address log (every presented address) -----------------
  logic [31:0] addr_log[$];
  always @(negedge clk) if (bus.pc_valid_o === 1'b1) addr_log.push_back(bus.pc_address_o);

  // ---------------- behavioural model ---------------------------------------
  // phase: 0 = waiting for a request, 1 = fetching, 2 = all bytes in
  logic        m_on = 1'b0;
  int          m_phase, m_iss, m_rx;
  logic        m_pend, m_ov;
  logic [31:0] m_base, m_ow, m_opc;

  always @(negedge clk) begin : model
    logic        e_pcv, e_rdy, grant, n_ov;
    logic [31:0] e_addr;
    e_pcv  = m_on && (m_phase == 1) && (m_iss < NBYTES);
    e_addr = e_pcv ? m_base + 32'(m_iss) : 32'h0;
    e_rdy  = m_on && (rst === 1'b1) && (m_phase == 0) && (!m_ov || !bus.stall_id_i);
    if (m_on) begin
      chk("pc_valid", 32'(bus.pc_valid_o), 32'(e_pcv));
      chk("pc_address", bus.pc_address_o, e_addr);
      chk("req_ready", 32'(bus.req_ready_o), 32'(e_rdy));
      chk("inst_valid", 32'(bus.inst_valid_o), 32'(m_ov));
      if (m_ov) begin
        chk("inst", bus.inst_o, m_ow);
        chk("inst_pc", bus.inst_pc_o, m_opc);
      end
    end
    if (rst !== 1'b1) begin
      m_on = 1'b1; m_phase = 0; m_iss = 0; m_rx = 0;
      m_pend = 1'b0; m_ov = 1'b0; m_base = '0; m_ow = '0; m_opc = '0;
    end else if (m_on) begin
      grant = e_pcv && !bus.stall_if_i;
      n_ov  = m_ov && bus.stall_id_i;
      if (m_phase == 2) begin
        if (!bus.flush_i) begin
          n_ov  = 1'b1;
          m_ow  = ref_word(m_base);
          m_opc = m_base;
        end
        m_phase = 0;
      end else if (m_phase == 1) begin
        if (m_pend) begin
          m_rx = m_rx + 1;
          if (m_rx == NBYTES) m_phase = 2;
        end
        m_pend = grant;
        if (grant) m_iss = m_iss + 1;
      end
      if (bus.flush_i) begin
        n_ov = 1'b0; m_phase = 0; m_iss = 0; m_rx = 0; m_pend = 1'b0;
      end
      if (bus.req_valid_i && (e_rdy || bus.flush_i)) begin
        m_phase = 1; m_base = bus.req_pc_i; m_iss = 0; m_rx = 0; m_pend = 1'b0;
      end
      m_ov = n_ov;
    end
  end

  // ---------------- stimulus helpers ----------------------------------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.req_valid_i = 1'b0;
    bus.req_pc_i    = '0;
    bus.flush_i     = 1'b0;
    bus.stall_if_i  = 1'b0;
    bus.stall_id_i  = 1'b0;
  endtask

  // Present a request until accepted; returns in the drive phase after.
  task automatic start_req(input logic [31:0] pc, output int acc);
    bus.req_valid_i = 1'b1;
    bus.req_pc_i    = pc;
    acc = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.req_ready_o === 1'b1) begin
        acc = cyc;
        break;
      end
      next_cycle();
    end
    chk("accept", 32'(acc >= 0), 32'd1);
    next_cycle();
    bus.req_valid_i = 1'b0;
  endtask

  // Wait (bounded) for inst_valid_o; stall_if_i pulsed at t0+stall_cyc.
  task automatic wait_inst(input int t0, input int stall_cyc, output int lat,
                           output logic [31:0] w, output logic [31:0] pc);
    lat = -1; w = '0; pc = '0;
    for (int k = 0; k < 40; k++) begin
      bus.stall_if_i = ((cyc - t0) == stall_cyc);
      @(negedge clk);
      if (bus.inst_valid_o === 1'b1) begin
        lat = cyc - t0;
        w   = bus.inst_o;
        pc  = bus.inst_pc_o;
        break;
      end
      next_cycle();
    end
    if (lat < 0) chk("inst_valid_seen", 32'(bus.inst_valid_o), 32'd1);
    $display("fetch inst_pc=%08h inst=%08h latency=%0d", pc, w, lat);
  endtask

  task automatic check_log(input string tag, input logic [31:0] e [5], input int n);
    chk({tag, "_log_len"}, 32'(addr_log.size()), 32'(n));
    for (int k = 0; k < n && k < addr_log.size(); k++) begin
      chk($sformatf("%s_log[%0d]", tag, k), addr_log[k], e[k]);
    end
  endtask

  // ---------------- main sequence -------------------------------------------
  initial begin
    int          acc, lat, t3;
    logic [31:0] w, pc;
    drive_idle();
    rst = 1'b0;
    bus.ram_byte_i = '0;
    repeat (3) next_cycle();
    @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready_o), 32'd0);
    chk("rst_pc_valid", 32'(bus.pc_valid_o), 32'd0);
    chk("rst_inst_valid", 32'(bus.inst_valid_o), 32'd0);
    chk("rst_inst", bus.inst_o, 32'h0);
    next_cycle();
    rst = 1'b1;

    // plain fetch
    addr_log.delete();
    start_req(32'h1000, acc);
    wait_inst(acc, -1, lat, w, pc);
    chk("t1_latency", 32'(lat), 32'd7);
    chk("t1_inst", w, 32'h00100513);
    chk("t1_pc", pc, 32'h1000);
    next_cycle();
    check_log("t1", '{32'h1000, 32'h1001, 32'h1002, 32'h1003, 32'h0}, 4);

    // stall_if on the second issue cycle
    addr_log.delete();
    start_req(32'h1000, acc);
    wait_inst(acc, 2, lat, w, pc);
    chk("t2_latency", 32'(lat), 32'd8);
    chk("t2_inst", w, 32'h00100513);
    next_cycle();
    bus.stall_if_i = 1'b0;
    check_log("t2", '{32'h1000, 32'h1001, 32'h1001, 32'h1002, 32'h1003}, 5);

    // flush with a new request after two bytes received
    start_req(32'h1000, acc);
    repeat (3) next_cycle();
    bus.flush_i = 1'b1; bus.req_valid_i = 1'b1; bus.req_pc_i = 32'h2000;
    t3 = cyc;
    next_cycle();
    bus.flush_i = 1'b0; bus.req_valid_i = 1'b0;
    addr_log.delete();
    wait_inst(t3, -1, lat, w, pc);
    chk("t3_latency", 32'(lat), 32'd7);
    chk("t3_pc", pc, 32'h2000);
    chk("t3_inst", w, 32'h00500093);
    next_cycle();
    check_log("t3", '{32'h2000, 32'h2001, 32'h2002, 32'h2003, 32'h0}, 4);

    // ID back-pressure holds the output
    bus.stall_id_i = 1'b1;
    start_req(32'h3000, acc);
    wait_inst(acc, -1, lat, w, pc);
    chk("t4_inst", w, ref_word(32'h3000));
    next_cycle();
    bus.req_valid_i = 1'b1; bus.req_pc_i = 32'h4000;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t4_hold_valid", 32'(bus.inst_valid_o), 32'd1);
      chk("t4_hold_inst", bus.inst_o, ref_word(32'h3000));
      chk("t4_hold_pc", bus.inst_pc_o, 32'h3000);
      chk("t4_hold_ready", 32'(bus.req_ready_o), 32'd0);
      chk("t4_hold_pc_valid", 32'(bus.pc_valid_o), 32'd0);
      next_cycle();
    end
    bus.stall_id_i = 1'b0;
    @(negedge clk);
    chk("t4_accept", 32'(bus.req_ready_o), 32'd1);
    acc = cyc;
    next_cycle();
    bus.req_valid_i = 1'b0;
    wait_inst(acc, -1, lat, w, pc);
    chk("t4_new_pc", pc, 32'h4000);
    chk("t4_new_latency", 32'(lat), 32'd7);
    next_cycle();

    // reset with a byte in flight
    start_req(32'h5000, acc);
    next_cycle();
    rst = 1'b0;
    next_cycle();
    @(negedge clk);
    chk("t5_pc_valid", 32'(bus.pc_valid_o), 32'd0);
    chk("t5_pc_address", bus.pc_address_o, 32'h0);
    chk("t5_inst_valid", 32'(bus.inst_valid_o), 32'd0);
    chk("t5_inst", bus.inst_o, 32'h0);
    chk("t5_inst_pc", bus.inst_pc_o, 32'h0);
    chk("t5_req_ready", 32'(bus.req_ready_o), 32'd0);
    next_cycle();
    rst = 1'b1;
    start_req(32'h5000, acc);
    wait_inst(acc, -1, lat, w, pc);
    chk("t5_inst_after", w, ref_word(32'h5000));
    chk("t5_latency", 32'(lat), 32'd7);
    next_cycle();

    // address wrap
    addr_log.delete();
    start_req(32'hFFFF_FFFE, acc);
    wait_inst(acc, -1, lat, w, pc);
    chk("t6_inst", w, ref_word(32'hFFFF_FFFE));
    next_cycle();
    check_log("t6", '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1, 32'h0}, 4);

    // random traffic, checked by the model every cycle
    for (int k = 0; k < 600; k++) begin
      rst             = ($urandom_range(0, 99) != 0);
      bus.req_valid_i = $urandom_range(0, 1) == 1;
      bus.req_pc_i    = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3))
                                                    : $urandom;
      bus.flush_i     = ($urandom_range(0, 15) == 0);
      bus.stall_if_i  = ($urandom_range(0, 2) == 0);
      bus.stall_id_i  = ($urandom_range(0, 2) == 0);
      next_cycle();
    end

    drive_idle();
    rst = 1'b1;
    repeat (20) next_cycle();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
